// File: rtl/rapid_pkg.sv
// Shared types for the rapid core: datapath width and the ID/EX and EX/MEM control bundles.
package rapid_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       load_upper_imm;
        logic       uncond_branch;
        logic       cond_branch;
        logic       iop;
        logic       alt_op;
        logic [2:0] fcs_opcode;
        logic       mem_read;
        logic       mem_write;
    } control_ex_s;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_funct3;
    } control_mem_s;

    function automatic control_ex_s control_ex_s_default();
        return '0;
    endfunction

    function automatic control_mem_s control_mem_s_default();
        return '0;
    endfunction

endpackage

// File: rtl/rapid_alu.sv
// Combinational RV32I ALU plus branch comparator; zero latency, no flow control.
module rapid_alu
    import rapid_pkg::*;
(
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic [XLEN-1:0] i_cmp_b,
    input  logic [2:0]      i_fcs_opcode,
    input  logic            i_alt_op,
    input  logic            i_iop,
    output logic [XLEN-1:0] o_result,
    output logic            o_branch_taken
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;
    logic       cmp_lt_s;
    logic       cmp_lt_u;

    assign shamt    = i_op_b[4:0];
    assign lt_s     = $signed(i_op_a) < $signed(i_op_b);
    assign lt_u     = i_op_a < i_op_b;
    assign cmp_lt_s = $signed(i_op_a) < $signed(i_cmp_b);
    assign cmp_lt_u = i_op_a < i_cmp_b;

    always_comb begin
        o_result = '0;
        unique case (i_fcs_opcode)
            3'b000: o_result = (i_alt_op && !i_iop) ? (i_op_a - i_op_b) : (i_op_a + i_op_b);
            3'b001: o_result = i_op_a << shamt;
            3'b010: o_result = {{(XLEN-1){1'b0}}, lt_s};
            3'b011: o_result = {{(XLEN-1){1'b0}}, lt_u};
            3'b100: o_result = i_op_a ^ i_op_b;
            3'b101: o_result = i_alt_op ? XLEN'($signed(i_op_a) >>> shamt) : (i_op_a >> shamt);
            3'b110: o_result = i_op_a | i_op_b;
            3'b111: o_result = i_op_a & i_op_b;
            default: o_result = '0;
        endcase
    end

    always_comb begin
        o_branch_taken = 1'b0;
        unique case (i_fcs_opcode)
            3'b000: o_branch_taken = (i_op_a == i_cmp_b);
            3'b001: o_branch_taken = (i_op_a != i_cmp_b);
            3'b100: o_branch_taken = cmp_lt_s;
            3'b101: o_branch_taken = !cmp_lt_s;
            3'b110: o_branch_taken = cmp_lt_u;
            3'b111: o_branch_taken = !cmp_lt_u;
            default: o_branch_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_logic.sv
// RV32I execute stage forming the EX/MEM register; 1-cycle latency, new instruction every cycle, no backpressure.
// EXEC_MISALIGN_CHECK_EN adds a registered o_misaligned flag for misaligned redirect targets.
module execute_logic
    import rapid_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_pc,
    input  control_ex_s     i_control_signal,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    output control_mem_s    o_control_signal,
    output logic            o_pc_load,
    output logic [XLEN-1:0] o_pc_ext,
    output logic [XLEN-1:0] o_memory_data,
    output logic [XLEN-1:0] o_rd_output
`ifdef EXEC_MISALIGN_CHECK_EN
    ,
    output logic            o_misaligned
`endif
);

    control_mem_s    ctl_d, ctl_q;
    logic            pc_load_d, pc_load_q;
    logic [XLEN-1:0] pc_ext_d, pc_ext_q;
    logic [XLEN-1:0] mem_data_d, mem_data_q;
    logic [XLEN-1:0] rd_output_d, rd_output_q;

    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] rs1_plus_imm;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] alu_result;
    logic            branch_taken;

    assign pc_plus_imm  = i_pc + i_imm;
    assign rs1_plus_imm = i_rs1 + i_imm;
    assign pc_plus_4    = i_pc + XLEN'(4);

    rapid_alu u_alu (
        .i_op_a         (i_rs1),
        .i_op_b         (i_control_signal.iop ? i_imm : i_rs2),
        .i_cmp_b        (i_rs2),
        .i_fcs_opcode   (i_control_signal.fcs_opcode),
        .i_alt_op       (i_control_signal.alt_op),
        .i_iop          (i_control_signal.iop),
        .o_result       (alu_result),
        .o_branch_taken (branch_taken)
    );

    always_comb begin
        ctl_d            = control_mem_s_default();
        ctl_d.rd         = i_control_signal.rd;
        ctl_d.reg_write  = i_control_signal.reg_write;
        ctl_d.mem_read   = i_control_signal.mem_read;
        ctl_d.mem_write  = i_control_signal.mem_write;
        ctl_d.mem_funct3 = i_control_signal.fcs_opcode;
        mem_data_d       = i_rs2;
        pc_load_d        = 1'b0;
        pc_ext_d         = '0;
        rd_output_d      = alu_result;
        if (i_control_signal.load_upper_imm) begin
            rd_output_d = i_control_signal.iop ? i_imm : pc_plus_imm;
        end else if (i_control_signal.uncond_branch) begin
            pc_load_d   = 1'b1;
            pc_ext_d    = i_control_signal.iop ? rs1_plus_imm : pc_plus_imm;
            rd_output_d = pc_plus_4;
        end else if (i_control_signal.cond_branch) begin
            // Target is driven even when not taken; only pc_load gates the redirect.
            pc_load_d   = branch_taken;
            pc_ext_d    = {pc_plus_imm[XLEN-1:1], 1'b0};
            rd_output_d = '0;
        end else if (i_control_signal.mem_read || i_control_signal.mem_write) begin
            rd_output_d = rs1_plus_imm;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctl_q       <= control_mem_s_default();
            pc_load_q   <= 1'b0;
            pc_ext_q    <= '0;
            mem_data_q  <= '0;
            rd_output_q <= '0;
        end else begin
            ctl_q       <= ctl_d;
            pc_load_q   <= pc_load_d;
            pc_ext_q    <= pc_ext_d;
            mem_data_q  <= mem_data_d;
            rd_output_q <= rd_output_d;
        end
    end

    assign o_control_signal = ctl_q;
    assign o_pc_load        = pc_load_q;
    assign o_pc_ext         = pc_ext_q;
    assign o_memory_data    = mem_data_q;
    assign o_rd_output      = rd_output_q;

`ifdef EXEC_MISALIGN_CHECK_EN
    logic misaligned_d, misaligned_q;

    assign misaligned_d = (pc_load_d && pc_ext_d[1])
                        || (!i_control_signal.load_upper_imm && i_control_signal.uncond_branch && pc_ext_d[0]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign o_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_execute_logic.sv
// Directed bench for execute_logic: hand-computed vectors checked one cycle after each issue.
module tb_execute_logic;
    import rapid_pkg::*;

    logic            i_clk;
    logic            i_rst_n;
    logic [31:0]     i_pc;
    control_ex_s     i_control_signal;
    logic [31:0]     i_rs1;
    logic [31:0]     i_rs2;
    logic [31:0]     i_imm;
    control_mem_s    o_control_signal;
    logic            o_pc_load;
    logic [31:0]     o_pc_ext;
    logic [31:0]     o_memory_data;
    logic [31:0]     o_rd_output;
`ifdef EXEC_MISALIGN_CHECK_EN
    logic            o_misaligned;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    execute_logic dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_pc             (i_pc),
        .i_control_signal (i_control_signal),
        .i_rs1            (i_rs1),
        .i_rs2            (i_rs2),
        .i_imm            (i_imm),
        .o_control_signal (o_control_signal),
        .o_pc_load        (o_pc_load),
        .o_pc_ext         (o_pc_ext),
        .o_memory_data    (o_memory_data),
        .o_rd_output      (o_rd_output)
`ifdef EXEC_MISALIGN_CHECK_EN
        ,
        .o_misaligned     (o_misaligned)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".rd_output"}, o_rd_output, 32'h0);
        chk({tag, ".pc_ext"},    o_pc_ext, 32'h0);
        chk({tag, ".pc_load"},   32'(o_pc_load), 32'h0);
        chk({tag, ".mem_data"},  o_memory_data, 32'h0);
        chk({tag, ".ctl"},       32'(o_control_signal), 32'h0);
    endtask

    // Issue one instruction and let it cross the EX/MEM register.
    task automatic issue(input control_ex_s c, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm);
        i_control_signal = c;
        i_pc  = pc;
        i_rs1 = rs1;
        i_rs2 = rs2;
        i_imm = imm;
        tick();
    endtask

    control_ex_s c;

    initial begin
        i_rst_n = 1'b0;
        i_control_signal = control_ex_s_default();
        i_pc = 32'h0; i_rs1 = 32'h0; i_rs2 = 32'h0; i_imm = 32'h0;
        tick();
        tick();
        check_zero("reset");
        #3 i_rst_n = 1'b1;
        tick();

        // LUI / AUIPC
        c = '0; c.load_upper_imm = 1'b1; c.iop = 1'b1; c.rd = 5'd5; c.reg_write = 1'b1;
        issue(c, 32'h1000, 32'h0, 32'h55, 32'h12345000);
        chk("lui.rd_output", o_rd_output, 32'h12345000);
        chk("lui.ctl_rd", 32'(o_control_signal.rd), 32'd5);
        chk("lui.reg_write", 32'(o_control_signal.reg_write), 32'd1);
        chk("lui.pc_load", 32'(o_pc_load), 32'd0);
        chk("lui.mem_data", o_memory_data, 32'h55);
        c.iop = 1'b0;
        issue(c, 32'h1000, 32'h0, 32'h0, 32'h12345000);
        chk("auipc.rd_output", o_rd_output, 32'h12346000);
        chk("auipc.pc_load", 32'(o_pc_load), 32'd0);

        // JAL / JALR
        c = '0; c.uncond_branch = 1'b1; c.rd = 5'd1; c.reg_write = 1'b1;
        issue(c, 32'h100, 32'h0, 32'h0, 32'h21);
        chk("jal.pc_load", 32'(o_pc_load), 32'd1);
        chk("jal.pc_ext", o_pc_ext, 32'h121);
        chk("jal.rd_output", o_rd_output, 32'h104);
`ifdef EXEC_MISALIGN_CHECK_EN
        chk("jal.misaligned", 32'(o_misaligned), 32'd1);
`endif
        c.iop = 1'b1;
        issue(c, 32'h100, 32'h2001, 32'h0, 32'h4);
        chk("jalr.pc_ext", o_pc_ext, 32'h2005);
        chk("jalr.rd_output", o_rd_output, 32'h104);
        chk("jalr.pc_load", 32'(o_pc_load), 32'd1);

        // Conditional branches, pc=0x200 imm=0x11 -> target 0x210
        c = '0; c.cond_branch = 1'b1; c.fcs_opcode = 3'b000;
        issue(c, 32'h200, 32'h7, 32'h7, 32'h11);
        chk("beq.pc_load", 32'(o_pc_load), 32'd1);
        chk("beq.pc_ext", o_pc_ext, 32'h210);
        chk("beq.rd_output", o_rd_output, 32'h0);
`ifdef EXEC_MISALIGN_CHECK_EN
        chk("beq.misaligned", 32'(o_misaligned), 32'd0);
`endif
        c.fcs_opcode = 3'b001;
        issue(c, 32'h200, 32'h7, 32'h7, 32'h11);
        chk("bne.pc_load", 32'(o_pc_load), 32'd0);
        c.fcs_opcode = 3'b100;
        issue(c, 32'h200, 32'hFFFFFFFF, 32'h0, 32'h11);
        chk("blt.pc_load", 32'(o_pc_load), 32'd1);
        chk("blt.funct3", 32'(o_control_signal.mem_funct3), 32'd4);
        c.fcs_opcode = 3'b110;
        issue(c, 32'h200, 32'hFFFFFFFF, 32'h0, 32'h11);
        chk("bltu.pc_load", 32'(o_pc_load), 32'd0);
        chk("bltu.pc_ext", o_pc_ext, 32'h210);
        c.fcs_opcode = 3'b101;
        issue(c, 32'h200, 32'hFFFFFFFF, 32'h0, 32'h11);
        chk("bge.pc_load", 32'(o_pc_load), 32'd0);
        c.fcs_opcode = 3'b111;
        issue(c, 32'h200, 32'hFFFFFFFF, 32'h0, 32'h11);
        chk("bgeu.pc_load", 32'(o_pc_load), 32'd1);
        c.fcs_opcode = 3'b010;
        issue(c, 32'h200, 32'h7, 32'h7, 32'h11);
        chk("b010.pc_load", 32'(o_pc_load), 32'd0);

        // ALU
        c = '0; c.reg_write = 1'b1; c.rd = 5'd9; c.alt_op = 1'b1; c.fcs_opcode = 3'b000;
        issue(c, 32'h300, 32'd5, 32'd7, 32'h0);
        chk("sub.rd_output", o_rd_output, 32'hFFFFFFFE);
        chk("sub.pc_ext", o_pc_ext, 32'h0);
        chk("sub.pc_load", 32'(o_pc_load), 32'd0);
        c.iop = 1'b1;
        issue(c, 32'h300, 32'd5, 32'd100, 32'd7);
        chk("addi_alt.rd_output", o_rd_output, 32'd12);
        c.iop = 1'b0; c.fcs_opcode = 3'b101;
        issue(c, 32'h0, 32'h80000000, 32'd4, 32'h0);
        chk("sra.rd_output", o_rd_output, 32'hF8000000);
        c.alt_op = 1'b0;
        issue(c, 32'h0, 32'h80000000, 32'd4, 32'h0);
        chk("srl.rd_output", o_rd_output, 32'h08000000);
        c.fcs_opcode = 3'b011;
        issue(c, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0);
        chk("sltu.rd_output", o_rd_output, 32'd1);
        c.fcs_opcode = 3'b010;
        issue(c, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0);
        chk("slt.rd_output", o_rd_output, 32'd0);
        c.fcs_opcode = 3'b001; c.iop = 1'b1;
        issue(c, 32'h0, 32'd1, 32'h0, 32'h24);
        chk("slli.rd_output", o_rd_output, 32'h10);
        c.iop = 1'b0; c.fcs_opcode = 3'b100;
        issue(c, 32'h0, 32'hF0F0, 32'hFF00, 32'h0);
        chk("xor.rd_output", o_rd_output, 32'h0FF0);
        c.fcs_opcode = 3'b110;
        issue(c, 32'h0, 32'hF0F0, 32'hFF00, 32'h0);
        chk("or.rd_output", o_rd_output, 32'hFFF0);
        c.fcs_opcode = 3'b111;
        issue(c, 32'h0, 32'hF0F0, 32'hFF00, 32'h0);
        chk("and.rd_output", o_rd_output, 32'hF000);

        // Store / load addressing, including wrap-around
        c = '0; c.mem_write = 1'b1; c.fcs_opcode = 3'b010;
        issue(c, 32'h0, 32'h1000, 32'hAB, 32'hFFFFFFFC);
        chk("sw.rd_output", o_rd_output, 32'hFFC);
        chk("sw.mem_data", o_memory_data, 32'hAB);
        chk("sw.mem_write", 32'(o_control_signal.mem_write), 32'd1);
        chk("sw.funct3", 32'(o_control_signal.mem_funct3), 32'd2);
        c = '0; c.mem_read = 1'b1;
        issue(c, 32'h0, 32'hFFFFFFFC, 32'h0, 32'd8);
        chk("lw_wrap.rd_output", o_rd_output, 32'h4);
        chk("lw.mem_read", 32'(o_control_signal.mem_read), 32'd1);

        // load_upper_imm outranks uncond_branch
        c = '0; c.load_upper_imm = 1'b1; c.uncond_branch = 1'b1; c.iop = 1'b1;
        issue(c, 32'h100, 32'h0, 32'h0, 32'hABCDE000);
        chk("prio.rd_output", o_rd_output, 32'hABCDE000);
        chk("prio.pc_load", 32'(o_pc_load), 32'd0);

        // Mid-stream asynchronous reset
        c = '0; c.uncond_branch = 1'b1; c.rd = 5'd3;
        issue(c, 32'h100, 32'h0, 32'h77, 32'h20);
        chk("prereset.pc_load", 32'(o_pc_load), 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        #3 i_rst_n = 1'b1;
        #1;
        check_zero("post_release");
        tick();
        chk("after_reset.pc_load", 32'(o_pc_load), 32'd1);
        chk("after_reset.pc_ext", o_pc_ext, 32'h120);
        chk("after_reset.rd_output", o_rd_output, 32'h104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
